mem_access_unit: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs: turns registered load/store control into transactions on the data-RAM request/response bus.
- Produces aligned, sign/zero-extended load data for WB and raises a stall request while an access is outstanding.
- Handles pipeline flush, including draining a bus transaction that has already been accepted.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-RAM access unit: turns the registered load/store control
// from EX/MEM into one request/response transaction on the data bus, returns
// lane-selected, extended load data to WB and stalls the pipe meanwhile.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_current_stage,
    input  logic                  mem_read_flag,
    input  logic                  mem_write_flag,
    input  logic                  mem_sign_ext_flag,
    input  logic [3:0]            mem_sel,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  ram_en,
    output logic [3:0]            ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic                  ram_addr_ok,
    input  logic                  ram_data_ok,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  stall_request
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t          state;
    size_t           size_d, size_q;
    logic [1:0]      lane_q;
    logic            sext_q;
    logic            is_load_q;
    logic            access;
    logic            is_store;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;

    // a store wins when both flags are set
    assign access   = mem_read_flag | mem_write_flag;
    assign is_store = mem_write_flag;

    // access size from the lane enables; anything irregular is a word
    always_comb begin
        size_d = SZ_WORD;
        case (mem_sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_d = SZ_BYTE;
            4'b0011, 4'b1100:                   size_d = SZ_HALF;
            default:                            size_d = SZ_WORD;
        endcase
    end

    // replicate right-aligned store data across every lane it could land in
    always_comb begin
        wdata_d = mem_write_data;
        case (size_d)
            SZ_BYTE: wdata_d = {4{mem_write_data[7:0]}};
            SZ_HALF: wdata_d = {2{mem_write_data[15:0]}};
            default: wdata_d = mem_write_data;
        endcase
    end

    // pick the addressed lane from the response and extend it to a full word
    always_comb begin
        rd_byte  = ram_rdata[{lane_q, 3'b000} +: 8];
        rd_half  = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_ext = ram_rdata;
        case (size_q)
            SZ_BYTE: load_ext = {{(DATA_WIDTH-8){sext_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_ext = {{(DATA_WIDTH-16){sext_q & rd_half[15]}}, rd_half};
            default: load_ext = ram_rdata;
        endcase
    end

    // stall while a transaction is pending; DONE lets the instruction retire
    always_comb begin
        stall_request = 1'b0;
        case (state)
            IDLE:             stall_request = access & ~flush;
            REQ, WAIT, DRAIN: stall_request = 1'b1;
            default:          stall_request = 1'b0;
        endcase
    end

    // transaction FSM with registered bus outputs and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ram_en    <= 1'b0;
            ram_wen   <= 4'b0000;
            ram_addr  <= '0;
            ram_wdata <= '0;
            load_data <= '0;
            size_q    <= SZ_WORD;
            lane_q    <= 2'b00;
            sext_q    <= 1'b0;
            is_load_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !flush) begin
                        state     <= REQ;
                        ram_en    <= 1'b1;
                        ram_addr  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                        ram_wen   <= is_store ? mem_sel : 4'b0000;
                        ram_wdata <= wdata_d;
                        size_q    <= size_d;
                        lane_q    <= mem_addr[1:0];
                        sext_q    <= mem_sign_ext_flag;
                        is_load_q <= ~is_store;
                    end
                end
                REQ: begin
                    // nothing accepted yet, so a flush simply withdraws the request
                    if (flush) begin
                        state  <= IDLE;
                        ram_en <= 1'b0;
                    end else if (ram_addr_ok) begin
                        state  <= WAIT;
                        ram_en <= 1'b0;
                    end
                end
                WAIT: begin
                    // accepted transaction must still complete on the bus
                    if (flush) begin
                        state <= DRAIN;
                    end else if (ram_data_ok) begin
                        state <= DONE;
                        if (is_load_q) load_data <= load_ext;
                    end
                end
                DONE: begin
                    // hold result until retire; never reissue for the same instruction
                    if (!stall_current_stage || flush) state <= IDLE;
                end
                DRAIN: begin
                    if (ram_data_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
